// File: rtl/cordic_output_stage_if.sv
// cordic_output_stage_if: sample input, FIFO head output and status of the CORDIC output stage
interface cordic_output_stage_if;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic [31:0] z_in;
  logic [1:0]  quad_in;
  logic        in_valid;
  logic [31:0] x_out;
  logic [31:0] y_out;
  logic [31:0] z_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;
  modport master (
    output x_in, y_in, z_in, quad_in, in_valid, out_ready,
    input  x_out, y_out, z_out, out_valid, level, overflow
  );
  modport slave (
    input  x_in, y_in, z_in, quad_in, in_valid, out_ready,
    output x_out, y_out, z_out, out_valid, level, overflow
  );
endinterface

// File: rtl/cordic_output_stage.sv
// cordic_output_stage: CORDIC gain removal, quadrant un-rotation and 4-entry FWFT output FIFO
module cordic_output_stage #(
  parameter logic [15:0] GAIN_Q16      = 16'h9B75,
  parameter logic [31:0] ANGLE_HALF_PI = 32'h4000_0000,
  parameter int          FIFO_DEPTH    = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cordic_output_stage_if.slave bus
);
  logic signed [47:0] px_q, px_d, py_q, py_d;
  logic [31:0] z1_q, z1_d;
  logic [1:0]  quad1_q, quad1_d;
  logic        v1_q, v1_d;
  logic [95:0] w2_q, w2_d;
  logic        v2_q, v2_d;
  logic [95:0] mem_q [4];
  logic [95:0] mem_d [4];
  logic [1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [2:0]  level_q, level_d;
  logic        ovf_q, ovf_d;
  logic [31:0] gx, gy;
  logic        full, pop, wr;
  // S1: signed sample times unsigned gain, both operands widened to 48 bits
  always_comb begin
    px_d    = $signed({{16{bus.x_in[31]}}, bus.x_in}) * $signed({32'd0, GAIN_Q16});
    py_d    = $signed({{16{bus.y_in[31]}}, bus.y_in}) * $signed({32'd0, GAIN_Q16});
    z1_d    = bus.z_in;
    quad1_d = bus.quad_in;
    v1_d    = bus.in_valid;
  end
  // S2: round to nearest Q16 then rotate back by the tagged quadrant
  always_comb begin
    gx   = 32'((px_q + 48'sd32768) >>> 16);
    gy   = 32'((py_q + 48'sd32768) >>> 16);
    w2_d = quad1_q == 2'b00 ? {gx, gy, z1_q} :
           quad1_q == 2'b01 ? {-gy, gx, z1_q + ANGLE_HALF_PI} :
           quad1_q == 2'b10 ? {-gx, -gy, z1_q + (ANGLE_HALF_PI << 1)} :
                              {gy, -gx, z1_q - ANGLE_HALF_PI};
    v2_d = v1_q;
  end
  // FIFO: a push into a full FIFO is accepted only when the head is popped on the same edge
  always_comb begin
    full    = level_q == 3'(FIFO_DEPTH);
    pop     = level_q != 3'd0 && bus.out_ready;
    wr      = v2_q && (!full || pop);
    for (int i = 0; i < 4; i++) mem_d[i] = (wr && wp_q == 2'(i)) ? w2_q : mem_q[i];
    wp_d    = wp_q + 2'(wr);
    rp_d    = rp_q + 2'(pop);
    level_d = level_q + 3'(wr) - 3'(pop);
    ovf_d   = ovf_q | (v2_q & full & ~pop);
  end
  // All state, cleared asynchronously so the head reads zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q    <= '0;
      py_q    <= '0;
      z1_q    <= '0;
      quad1_q <= '0;
      v1_q    <= 1'b0;
      w2_q    <= '0;
      v2_q    <= 1'b0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      z1_q    <= z1_d;
      quad1_q <= quad1_d;
      v1_q    <= v1_d;
      w2_q    <= w2_d;
      v2_q    <= v2_d;
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end
  assign {bus.x_out, bus.y_out, bus.z_out} = mem_q[rp_q];
  assign bus.out_valid = level_q != 3'd0;
  assign bus.level     = level_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cordic_output_stage.sv
// tb_cordic_output_stage: randomized and directed checks against a queue-based behavioural model
module tb_cordic_output_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cordic_output_stage_if bus();
  cordic_output_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [95:0] q[$];
  logic [96:0] s1, s2;
  logic        movf;
  logic [95:0] h, mw;
  int unsigned de [4] = '{1, 1, 2, 2};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Ideal result of one sample: round(v*K) in Q16, then undo the quarter-turn pre-rotation
  function automatic logic [95:0] calc(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic [1:0] qd);
    longint gx, gy;
    logic [31:0] a, b;
    gx = (longint'($signed(x)) * 39797 + 32768) >>> 16;
    gy = (longint'($signed(y)) * 39797 + 32768) >>> 16;
    a = gx[31:0];
    b = gy[31:0];
    case (qd)
      2'd0: return {a, b, z};
      2'd1: return {-b, a, z + 32'h4000_0000};
      2'd2: return {-a, -b, z + 32'h8000_0000};
      default: return {b, -a, z - 32'h4000_0000};
    endcase
  endfunction
  // Model: a sample enters a 4-deep queue two edges after it is taken; pop before push
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      s1 = '0;
      s2 = '0;
      movf = 1'b0;
    end else begin
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (s2[96]) begin
        if (q.size() < 4) q.push_back(s2[95:0]);
        else movf = 1'b1;
      end
      s2 = s1;
      s1 = {bus.in_valid, calc(bus.x_in, bus.y_in, bus.z_in, bus.quad_in)};
    end
  end
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("level", 32'(bus.level), 32'(q.size()));
      chk("overflow", 32'(bus.overflow), 32'(movf));
      if (q.size() != 0) begin
        h = q[0];
        chk("x_out", bus.x_out, h[95:64]);
        chk("y_out", bus.y_out, h[63:32]);
        chk("z_out", bus.z_out, h[31:0]);
      end
    end
  end
  task automatic drive(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input logic [1:0] qd);
    bus.x_in = x;
    bus.y_in = y;
    bus.z_in = z;
    bus.quad_in = qd;
    bus.in_valid = 1'b1;
  endtask
  task automatic lit(input string nm, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] z, input logic [1:0] qd,
                     input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez);
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive(x, y, z, qd);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 chk({nm, "_early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_x"}, bus.x_out, ex);
    chk({nm, "_y"}, bus.y_out, ey);
    chk({nm, "_z"}, bus.z_out, ez);
    @(posedge clk);
    #1 chk({nm, "_once"}, 32'(bus.out_valid), 32'd0);
  endtask
  initial begin
    bus.x_in = '0;
    bus.y_in = '0;
    bus.z_in = '0;
    bus.quad_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_x", bus.x_out, 32'd0);
    mw = calc(32'h1000_0000, 32'd0, 32'h1234, 2'd0);
    chk("model_gain", mw[95:64], 32'h09B7_5000);
    mw = calc(32'h1000_0000, 32'd0, 32'h1000_0000, 2'd2);
    chk("model_q2", mw[95:64], 32'hF648_B000);
    mw = calc(32'hFFFF_FFFF, 32'd0, 32'd0, 2'd0);
    chk("model_round", mw[95:64], 32'hFFFF_FFFF);
    lit("gain_q0", 32'h1000_0000, 0, 32'h0000_1234, 2'd0, 32'h09B7_5000, 0, 32'h0000_1234);
    lit("quad10", 32'h1000_0000, 0, 32'h1000_0000, 2'd2, 32'hF648_B000, 0, 32'h9000_0000);
    lit("quad01", 32'h1000_0000, 0, 32'h1000_0000, 2'd1, 0, 32'h09B7_5000, 32'h5000_0000);
    lit("quad11", 32'h1000_0000, 0, 32'h2000_0000, 2'd3, 0, 32'hF648_B000, 32'hE000_0000);
    lit("round_m1", 32'hFFFF_FFFF, 0, 0, 2'd0, 32'hFFFF_FFFF, 0, 0);
    lit("round_p1", 32'h0000_0001, 0, 0, 2'd0, 32'h0000_0001, 0, 0);
    lit("z_wrap", 0, 0, 32'hF000_0000, 2'd1, 0, 0, 32'h3000_0000);
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive(32'(i), 0, 0, 2'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_level", 32'(bus.level), 32'd4);
    chk("bp_overflow", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_x", bus.x_out, de[i]);
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    chk("drain_sticky", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i << 16), 32'(i), 32'(i), 2'(i));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("prerst_level", 32'(bus.level), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_level", 32'(bus.level), 32'd0);
    chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    chk("mid_rst_x", bus.x_out, 32'd0);
    chk("mid_rst_y", bus.y_out, 32'd0);
    chk("mid_rst_z", bus.z_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(bus.out_valid), 32'd0);
    end
    lit("post_rst", 32'h1000_0000, 0, 32'h0000_1234, 2'd0, 32'h09B7_5000, 0, 32'h0000_1234);
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive($urandom, $urandom, $urandom, 2'($urandom));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      chk("full_level", 32'(bus.level), 32'd4);
      chk("full_overflow", 32'(bus.overflow), 32'd0);
      drive($urandom, $urandom, $urandom, 2'($urandom));
      if (i == 2) bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) == 0 ? 32'h8000_0000 : $urandom,
            $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFF : $urandom,
            $urandom, 2'($urandom));
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
